// File: rtl/param_bus_mem.sv
// Parametrised memory-bus slave: write-protected ROM region, RAM above it,
// power-on fill, programmable wait states and a ready/error handshake.
module param_bus_mem #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned ROM_WORDS   = 4,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned INIT_VAL    = 108
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic              busy,
    output logic              wr_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] INIT_WORD = DATA_W'(INIT_VAL);
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {StInit, StIdle, StWait, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic rom_hit;
    assign rom_hit = 32'(addr_q) < ROM_WORDS;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ptr_q[ADDR_W-1:0];
        mem_wdata = INIT_WORD;

        unique case (state_q)
            StInit: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (cs && (rd || wr)) begin
                    addr_d  = addr;
                    wdat_d  = data_in;
                    rd_d    = rd;
                    wr_d    = wr;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? StAccess : StWait;
                end
            end
            StWait: begin
                // Abort takes priority over reaching the end of the wait.
                if (!cs) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = StAccess;
                end
            end
            StAccess: begin
                ready_d = 1'b1;
                state_d = StDone;
                if (rd_q && !wr_q) begin
                    dout_d = mem[addr_q];
                end else if (wr_q && !rd_q && !rom_hit) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_q;
                    mem_wdata = wdat_q;
                end else begin
                    err_d = 1'b1;
                end
            end
            StDone: begin
                if (!cs) state_d = StIdle;
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            ptr_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset; contents are defined by the init fill.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign data_out = dout_q;
    assign ready    = ready_q;
    assign wr_err   = err_q;
    assign busy     = busy_q;

endmodule
